vga_timing_gen: RTL and testbench

Parametrised raster timing generator for VGA-style displays; successor to the fixed 800x600 counter logic used in top-level test designs. It produces pixel/line counters, hsync/vsync with programmable polarity, a data-enable, and frame/line strobes. It sits between the pixel-clock PLL and any pixel source (pattern generator, framebuffer reader). A configurable output delay aligns sync/DE with downstream pixel-pipeline latency.

---
 rtl/vga_timing_gen.sv | 154 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Produces pixel/line counters, hsync/vsync with programmable polarity, a
// data-enable, line/frame strobes and a wrapping completed-frame counter.
// Sync and DE pass through a PIPE_DELAY-stage, ce-qualified delay line so
// they can be aligned with downstream pixel-pipeline latency.
//
// Ports:
//   i_clock        pixel clock
//   i_reset_n      asynchronous active-low reset
//   i_ce           pixel enable; all state advances only when high
//   o_x, o_y       current horizontal / vertical count (counter registers)
//   o_hsync        horizontal sync, active level H_POL, delayed PIPE_DELAY
//   o_vsync        vertical sync, active level V_POL, delayed PIPE_DELAY
//   o_de           active-video enable, delayed PIPE_DELAY
//   o_line_start   high while o_x == 0
//   o_frame_start  high while o_x == 0 and o_y == 0
//   o_frame_count  completed-frame count, wraps at 2^FCW
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE   = 800,
   parameter int unsigned H_FP       = 40,
   parameter int unsigned H_SYNC     = 128,
   parameter int unsigned H_BP       = 88,
   parameter int unsigned V_ACTIVE   = 600,
   parameter int unsigned V_FP       = 1,
   parameter int unsigned V_SYNC     = 4,
   parameter int unsigned V_BP       = 23,
   parameter bit          H_POL      = 1'b1,
   parameter bit          V_POL      = 1'b1,
   parameter int unsigned CW         = 11,
   parameter int unsigned PIPE_DELAY = 1,
   parameter int unsigned FCW        = 8
) (
   input  logic           i_clock,
   input  logic           i_reset_n,
   input  logic           i_ce,
   output logic [CW-1:0]  o_x,
   output logic [CW-1:0]  o_y,
   output logic           o_hsync,
   output logic           o_vsync,
   output logic           o_de,
   output logic           o_line_start,
   output logic           o_frame_start,
   output logic [FCW-1:0] o_frame_count
);

   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;
   // One extra bit so boundaries equal to 2^CW still compare correctly.
   localparam int unsigned XW       = CW + 1;
   localparam longint unsigned CAP  = 64'd1 << CW;

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

   // Elaboration-time parameter sanity checks
   generate
      if (longint'(H_TOTAL) > CAP || longint'(V_TOTAL) > CAP) begin : g_cw_check
         $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
      end
      if (H_TOTAL == 0 || V_TOTAL == 0) begin : g_total_check
         $error("vga_timing_gen: H_TOTAL and V_TOTAL must be non-zero");
      end
      if (PIPE_DELAY > 15) begin : g_delay_check
         $error("vga_timing_gen: PIPE_DELAY must be 0..15");
      end
   endgenerate

   logic [CW-1:0]  x;
   logic [CW-1:0]  y;
   logic [FCW-1:0] frame_count;

   // Raster counters and frame counter
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         x           <= '0;
         y           <= '0;
         frame_count <= '0;
      end else if (i_ce) begin
         if (x == H_LAST) begin
            x <= '0;
            if (y == V_LAST) begin
               y           <= '0;
               frame_count <= frame_count + FCW'(1);
            end else begin
               y <= y + CW'(1);
            end
         end else begin
            x <= x + CW'(1);
         end
      end
   end

   logic [XW-1:0] x_w;
   logic [XW-1:0] y_w;
   logic          de_raw;
   logic          hs_raw;
   logic          vs_raw;

   // Half-open interval decode of the current position
   always_comb begin
      x_w    = {1'b0, x};
      y_w    = {1'b0, y};
      de_raw = (x_w < XW'(H_ACTIVE)) && (y_w < XW'(V_ACTIVE));
      hs_raw = (x_w >= XW'(HS_START)) && (x_w < XW'(HS_END));
      vs_raw = (y_w >= XW'(VS_START)) && (y_w < XW'(VS_END));
   end

   logic de_d;
   logic hs_d;
   logic vs_d;

   // Delay line stores raw (active-high) values; reset value 0 = inactive
   generate
      if (PIPE_DELAY == 0) begin : g_nodelay
         assign de_d = de_raw;
         assign hs_d = hs_raw;
         assign vs_d = vs_raw;
      end else begin : g_delay
         logic [PIPE_DELAY-1:0] de_sr;
         logic [PIPE_DELAY-1:0] hs_sr;
         logic [PIPE_DELAY-1:0] vs_sr;

         always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
               de_sr <= '0;
               hs_sr <= '0;
               vs_sr <= '0;
            end else if (i_ce) begin
               de_sr <= (de_sr << 1) | PIPE_DELAY'(de_raw);
               hs_sr <= (hs_sr << 1) | PIPE_DELAY'(hs_raw);
               vs_sr <= (vs_sr << 1) | PIPE_DELAY'(vs_raw);
            end
         end

         assign de_d = de_sr[PIPE_DELAY-1];
         assign hs_d = hs_sr[PIPE_DELAY-1];
         assign vs_d = vs_sr[PIPE_DELAY-1];
      end
   endgenerate

   assign o_x           = x;
   assign o_y           = y;
   assign o_de          = de_d;
   assign o_hsync       = hs_d ~^ H_POL;
   assign o_vsync       = vs_d ~^ V_POL;
   assign o_line_start  = (x == '0);
   assign o_frame_start = (x == '0) && (y == '0);
   assign o_frame_count = frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen with a reduced raster (16 x 8 totals).
// Instance a: active-high syncs, PIPE_DELAY=1, CW=4 (exact fit), FCW=2.
// Instance b: active-low syncs, PIPE_DELAY=3, CW=5, FCW=8.
// Horizontal: active 0..7, fp 8..9, sync 10..12, bp 13..15.
// Vertical:   active 0..3, fp 4, sync 5..6, bp 7.
// n = number of ce edges since reset release; x = n%16, y = (n/16)%8.
module tb_vga_timing_gen;

   logic       clk;
   logic       rst_n;
   logic       ce;

   logic [3:0] a_x, a_y;
   logic       a_hs, a_vs, a_de, a_ls, a_fs;
   logic [1:0] a_fc;

   logic [4:0] b_x, b_y;
   logic       b_hs, b_vs, b_de, b_ls, b_fs;
   logic [7:0] b_fc;

   int checks = 0;
   int errors = 0;
   int n = 0;

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_POL(1'b1), .V_POL(1'b1), .CW(4), .PIPE_DELAY(1), .FCW(2)
   ) u_a (
      .i_clock(clk), .i_reset_n(rst_n), .i_ce(ce),
      .o_x(a_x), .o_y(a_y), .o_hsync(a_hs), .o_vsync(a_vs), .o_de(a_de),
      .o_line_start(a_ls), .o_frame_start(a_fs), .o_frame_count(a_fc)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_POL(1'b0), .V_POL(1'b0), .CW(5), .PIPE_DELAY(3), .FCW(8)
   ) u_b (
      .i_clock(clk), .i_reset_n(rst_n), .i_ce(ce),
      .o_x(b_x), .o_y(b_y), .o_hsync(b_hs), .o_vsync(b_vs), .o_de(b_de),
      .o_line_start(b_ls), .o_frame_start(b_fs), .o_frame_count(b_fc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (n=%0d)", tag, obs, exp, n);
      end
   endtask

   // Advance raw clocks; sample 1 time unit after the edge
   task automatic clocks(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   // Advance with ce held high until n reaches target
   task automatic adv_to(input int target);
      ce = 1'b1;
      clocks(target - n);
      n = target;
   endtask

   initial begin
      rst_n = 1'b0;
      ce    = 1'b1;
      clocks(5);

      // Reset state
      check("rst_a_x", a_x, 0);
      check("rst_a_y", a_y, 0);
      check("rst_a_de", a_de, 0);
      check("rst_a_hs", a_hs, 0);
      check("rst_a_vs", a_vs, 0);
      check("rst_a_fc", a_fc, 0);
      check("rst_a_ls", a_ls, 1);
      check("rst_a_fs", a_fs, 1);
      check("rst_b_hs", b_hs, 1);
      check("rst_b_vs", b_vs, 1);
      check("rst_b_de", b_de, 0);

      rst_n = 1'b1;
      n = 0;

      // First ce edges: DE latency of 1 (a) and 3 (b)
      adv_to(1);
      check("n1_a_x", a_x, 1);
      check("n1_a_de", a_de, 1);
      check("n1_b_de", b_de, 0);
      adv_to(2);
      check("n2_b_de", b_de, 0);
      adv_to(3);
      check("n3_b_de", b_de, 1);
      check("n3_b_x", b_x, 3);

      // Horizontal: de ends after x=7, hsync covers x=10..12
      adv_to(8);
      check("n8_a_de", a_de, 1);
      adv_to(9);
      check("n9_a_de", a_de, 0);
      adv_to(10);
      check("n10_a_hs", a_hs, 0);
      adv_to(11);
      check("n11_a_hs", a_hs, 1);
      adv_to(12);
      check("n12_b_hs", b_hs, 1);
      adv_to(13);
      check("n13_a_hs", a_hs, 1);
      check("n13_b_hs", b_hs, 0);
      adv_to(14);
      check("n14_a_hs", a_hs, 0);
      adv_to(15);
      check("n15_a_x", a_x, 15);
      check("n15_a_ls", a_ls, 0);
      check("n15_b_hs", b_hs, 0);
      adv_to(16);
      check("n16_a_x", a_x, 0);
      check("n16_a_y", a_y, 1);
      check("n16_a_ls", a_ls, 1);
      check("n16_a_fs", a_fs, 0);
      check("n16_b_hs", b_hs, 1);

      // Vertical: vsync covers lines 5..6 (n 80..111)
      adv_to(80);
      check("n80_a_y", a_y, 5);
      check("n80_a_vs", a_vs, 0);
      adv_to(81);
      check("n81_a_vs", a_vs, 1);
      adv_to(82);
      check("n82_b_vs", b_vs, 1);
      adv_to(83);
      check("n83_b_vs", b_vs, 0);
      adv_to(112);
      check("n112_a_y", a_y, 7);
      check("n112_a_vs", a_vs, 1);
      adv_to(113);
      check("n113_a_vs", a_vs, 0);
      check("n113_b_vs", b_vs, 0);

      // Frame wrap and frame counter
      adv_to(127);
      check("n127_a_x", a_x, 15);
      check("n127_a_y", a_y, 7);
      check("n127_a_fc", a_fc, 0);
      adv_to(128);
      check("n128_a_x", a_x, 0);
      check("n128_a_y", a_y, 0);
      check("n128_a_fc", a_fc, 1);
      check("n128_a_fs", a_fs, 1);
      check("n128_a_de", a_de, 0);
      adv_to(129);
      check("n129_a_de", a_de, 1);
      adv_to(256);
      check("n256_a_fc", a_fc, 2);
      adv_to(384);
      check("n384_a_fc", a_fc, 3);
      adv_to(512);
      check("n512_a_fc_wrap", a_fc, 0);
      check("n512_b_fc", b_fc, 4);
      check("n512_a_fs", a_fs, 1);

      // ce on 1-of-2 clocks: 20 clocks give 10 ce edges
      for (int i = 0; i < 10; i++) begin
         ce = 1'b0;
         clocks(1);
         ce = 1'b1;
         clocks(1);
      end
      n = 522;
      check("half_a_x", a_x, 10);
      check("half_a_hs", a_hs, 0);
      ce = 1'b0;
      clocks(3);
      check("hold_a_x", a_x, 10);
      check("hold_a_hs", a_hs, 0);
      check("hold_b_x", b_x, 10);
      adv_to(523);
      check("n523_a_hs", a_hs, 1);

      // Async reset mid-line, no clock edge needed
      adv_to(533);
      check("n533_a_x", a_x, 5);
      check("n533_a_y", a_y, 1);
      check("n533_a_de", a_de, 1);
      check("n533_b_de", b_de, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_a_x", a_x, 0);
      check("arst_a_y", a_y, 0);
      check("arst_a_de", a_de, 0);
      check("arst_b_de", b_de, 0);
      check("arst_b_hs", b_hs, 1);
      check("arst_a_vs", a_vs, 0);
      check("arst_b_fc", b_fc, 0);

      rst_n = 1'b1;
      clocks(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
